decrement_borrow_counter: RTL

Synchronous, loadable down-counter (N+1 bits wide) with borrow detection and one-shot/periodic reload. It complements the team's increment ripple-carry counter: it counts the other direction, and it turns the underflow (borrow) into a clean one-cycle pulse. It sits beside the up-counters as a programmable interval timer/divider. A small control FSM (IDLE/RUN/DONE) sequences it. Everything is clocked by one clock edge; there is no ripple clocking.

---
 rtl/decrement_borrow_counter.sv | 69 ++++++
 1 files changed

// File: rtl/decrement_borrow_counter.sv
// Loadable N+1-bit down-counter with a registered one-cycle borrow pulse on underflow
// and one-shot or periodic reload, sequenced by a small IDLE/RUN/DONE controller.
module decrement_borrow_counter #(
    parameter int N = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       en,
    input  logic       periodic,
    input  logic [N:0] d,
    output logic [N:0] q,
    output logic       borrow,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N:0] ONE  = {{N{1'b0}}, 1'b1};
    localparam logic [N:0] ZERO = '0;

    state_t     state;
    logic [N:0] reload;

    // Priority is stop, then start, then counting; underflow reloads or stops, never wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            q      <= ZERO;
            reload <= ZERO;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            borrow <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start) begin
                q      <= d;
                reload <= d;
                state  <= RUN;
                busy   <= 1'b1;
                done   <= 1'b0;
            end else if (state == RUN && en) begin
                if (q != ZERO) begin
                    q <= q - ONE;
                end else begin
                    borrow <= 1'b1;
                    if (periodic) begin
                        q <= reload;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
